// File: rtl/lut_arbiter.sv
// Two-requester round-robin arbiter in front of a combinational constant LUT.
// Each granted lookup takes three cycles: grant (IDLE), LUT access (LOOKUP),
// response (RESP). Keys above KEY_MAX return 0 and raise err with the ack.
module lut_arbiter #(
  parameter int KEY_MAX = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [4:0] key0,
  input  logic       req1,
  input  logic [4:0] key1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       lut_en,
  output logic [4:0] lut_key,
  input  logic [7:0] lut_value,
  output logic       busy,
  output logic [7:0] conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_e;

  localparam logic [4:0] KEY_MAX_L = 5'(KEY_MAX);

  state_e     state_q, state_d;
  logic       gid_q, gid_d;
  logic [4:0] key_q, key_d;
  logic       last_q, last_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] cnt_q, cnt_d;
  logic       key_bad;

  assign key_bad      = (key_q > KEY_MAX_L);
  assign busy         = (state_q != IDLE);
  assign rdata        = rdata_q;
  assign conflict_cnt = cnt_q;

  // Next-state, grant selection and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    key_d   = key_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    err     = 1'b0;
    lut_en  = 1'b0;
    lut_key = '0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On conflict the requester not granted last wins.
          gid_d   = (req0 && req1) ? ~last_q : req1;
          key_d   = gid_d ? key1 : key0;
          last_d  = gid_d;
          state_d = LOOKUP;
          if (req0 && req1 && (cnt_q != '1)) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      LOOKUP: begin
        lut_en  = 1'b1;
        lut_key = key_q;
        rdata_d = key_bad ? '0 : lut_value;
        state_d = RESP;
      end
      RESP: begin
        ack0    = ~gid_q;
        ack1    = gid_q;
        err     = key_bad;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; last_q resets to 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gid_q   <= 1'b0;
      key_q   <= '0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      key_q   <= key_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lut_arbiter.sv
// Bench for lut_arbiter: directed scenarios plus randomized requesters,
// checked against a timestamp-based transaction model.
module tb_lut_arbiter;

  localparam int KEY_MAX = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [4:0] key0 = '0;
  logic [4:0] key1 = '0;
  logic       ack0, ack1, err, lut_en, busy;
  logic [7:0] rdata, conflict_cnt, lut_value;
  logic [4:0] lut_key;
  logic [7:0] lut_tbl [32];

  always #5 clk = ~clk;

  assign lut_value = lut_tbl[lut_key];

  lut_arbiter #(.KEY_MAX(KEY_MAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .key0        (key0),
    .req1        (req1),
    .key1        (key1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata       (rdata),
    .err         (err),
    .lut_en      (lut_en),
    .lut_key     (lut_key),
    .lut_value   (lut_value),
    .busy        (busy),
    .conflict_cnt(conflict_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: a grant at edge g means LUT access in the interval
  // after g, ack in the interval after g+1, and no new grant before edge g+3.
  int         e = 0;
  int         next_arb = 0;
  int         g_edge = -100;
  int         g_id = 0;
  logic [4:0] g_key = '0;
  logic [7:0] m_rdata = '0;
  int         m_cnt = 0;
  int         m_last = 1;

  int p0 = 0;
  int p1 = 0;
  bit rand_keys = 0;
  bit seen0, seen1;

  task automatic model_init();
    g_edge   = -100;
    next_arb = 0;
    m_rdata  = '0;
    m_cnt    = 0;
    m_last   = 1;
  endtask

  task automatic step();
    logic s0, s1;
    @(posedge clk);
    s0 = req0;
    s1 = req1;
    e++;
    if (e == g_edge + 1)
      m_rdata = (int'(g_key) > KEY_MAX) ? 8'd0 : lut_tbl[g_key];
    if (e >= next_arb && (s0 || s1)) begin
      if (s0 && s1) begin
        g_id = (m_last == 1) ? 0 : 1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        g_id = s0 ? 0 : 1;
      end
      m_last   = g_id;
      g_key    = (g_id == 1) ? key1 : key0;
      g_edge   = e;
      next_arb = e + 3;
    end
    #1;
    check("busy", busy, (e == g_edge) || (e == g_edge + 1));
    check("lut_en", lut_en, e == g_edge);
    check("lut_key", lut_key, (e == g_edge) ? 32'(g_key) : 32'd0);
    check("ack0", ack0, (e == g_edge + 1) && (g_id == 0));
    check("ack1", ack1, (e == g_edge + 1) && (g_id == 1));
    check("err", err, (e == g_edge + 1) && (int'(g_key) > KEY_MAX));
    check("rdata", rdata, m_rdata);
    check("conflict_cnt", conflict_cnt, m_cnt);
    seen0 = ack0;
    seen1 = ack1;
    // Requester behaviour: drop after ack, optionally raise a new request.
    if (ack0) req0 = 1'b0;
    else if (!req0 && ($urandom_range(99) < p0)) begin
      req0 = 1'b1;
      if (rand_keys) key0 = 5'($urandom_range(31));
    end
    if (ack1) req1 = 1'b0;
    else if (!req1 && ($urandom_range(99) < p1)) begin
      req1 = 1'b1;
      if (rand_keys) key1 = 5'($urandom_range(31));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_err", err, 0);
    check("rst_lut_en", lut_en, 0);
    check("rst_lut_key", lut_key, 0);
    check("rst_rdata", rdata, 0);
    check("rst_conflict_cnt", conflict_cnt, 0);
  endtask

  task automatic do_reset(input int hold);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (hold) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    model_init();
  endtask

  task automatic run_until_ack(output int id, output logic [7:0] rd, output logic er,
                               output logic [7:0] cnt);
    id  = -1;
    rd  = '0;
    er  = 1'b0;
    cnt = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (seen0 || seen1) begin
        id  = seen1 ? 1 : 0;
        rd  = rdata;
        er  = err;
        cnt = conflict_cnt;
        return;
      end
    end
    check("ack_timeout", 0, 1);
  endtask

  initial begin
    int         id;
    logic [7:0] rd, cnt;
    logic       er;
    bit         got_lut;

    for (int unsigned k = 0; k < 32; k++) lut_tbl[k] = 8'($urandom_range(255));
    lut_tbl[1] = 8'd63;
    lut_tbl[3] = 8'd1;
    lut_tbl[4] = 8'd64;
    lut_tbl[8] = 8'hAA;

    // Reset with both requests held, then alternating grants starting at requester 0.
    req0 = 1'b1;
    req1 = 1'b1;
    key0 = 5'd1;
    key1 = 5'd3;
    do_reset(2);
    p0 = 100;
    p1 = 100;
    for (int k = 0; k < 4; k++) begin
      run_until_ack(id, rd, er, cnt);
      check("rr_grant", id, k % 2);
      check("rr_rdata", rd, (k % 2) ? 8'd1 : 8'd63);
      check("rr_cnt", cnt, k + 1);
    end
    p0 = 0;
    p1 = 0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) step();

    // Invalid key from requester 1.
    req1 = 1'b1;
    key1 = 5'd8;
    run_until_ack(id, rd, er, cnt);
    check("bad_key_id", id, 1);
    check("bad_key_rdata", rd, 0);
    check("bad_key_err", er, 1);
    repeat (2) step();

    // Single valid request from requester 0.
    req0 = 1'b1;
    key0 = 5'd4;
    run_until_ack(id, rd, er, cnt);
    check("single_id", id, 0);
    check("single_rdata", rd, 64);
    check("single_err", er, 0);
    repeat (2) step();

    // Reset during LOOKUP aborts; held request is serviced after release.
    req0 = 1'b1;
    key0 = 5'd3;
    got_lut = 0;
    for (int i = 0; i < 5 && !got_lut; i++) begin
      step();
      got_lut = lut_en;
    end
    check("abort_saw_lookup", got_lut, 1);
    do_reset(2);
    run_until_ack(id, rd, er, cnt);
    check("abort_retry_id", id, 0);
    check("abort_retry_rdata", rd, 1);
    repeat (2) step();

    // Randomized traffic with occasional asynchronous resets.
    rand_keys = 1;
    p0 = 40;
    p1 = 40;
    for (int unsigned k = 0; k < 3; k++) begin
      repeat (500) step();
      do_reset(1);
    end
    p0 = 0;
    p1 = 0;
    rand_keys = 0;
    repeat (5) step();
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) step();

    // Long conflicting run: counter must stop at 255.
    req0 = 1'b1;
    req1 = 1'b1;
    key0 = 5'd1;
    key1 = 5'd3;
    do_reset(1);
    p0 = 100;
    p1 = 100;
    for (int k = 0; k < 300; k++) run_until_ack(id, rd, er, cnt);
    check("sat_cnt", conflict_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
